// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the unified-memory port arbiter and its
// latency counter (also used by the cache-fill controller).
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_IF   = 2'd1,
      ARB_DM   = 2'd2
   } arb_state_t;

   localparam int MEM_LAT_DEFAULT = 2;
   localparam int CNT_W           = 4;

   typedef struct packed {
      arb_state_t       state;
      logic             last_dm;
      logic [CNT_W-1:0] lat_count;
   } arb_dbg_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that stops at zero; done is high whenever the count is zero.
module mem_lat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         done
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Define MEM_PORT_ARB_STATS_EN to add the saturating conflict_cnt output.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_ack,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          stall_if,
   output logic          stall_mem,
   output arb_dbg_t      dbg
`ifdef MEM_PORT_ARB_STATS_EN
   ,
   output logic [15:0]   conflict_cnt
`endif
);

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

   arb_state_t       state_q, state_d;
   logic             last_dm_q;
   logic             busy, lat_done, done, decide;
   logic             if_m, dm_m, grant_if, grant_dm, grant;
   logic [CNT_W-1:0] lat_count;

   assign busy   = (state_q != ARB_IDLE);
   assign done   = busy & lat_done;
   assign decide = ~busy | done;

   // The current owner is masked in its capture cycle and its ack cycle, so the
   // other side can take the port with no gap while the owner cannot re-grant.
   assign if_m = if_req & ~if_ack & ~(done & (state_q == ARB_IF));
   assign dm_m = dm_req & ~dm_ack & ~(done & (state_q == ARB_DM));

   always_comb begin
      grant_if = 1'b0;
      grant_dm = 1'b0;
      if (decide) begin
         if (if_m && dm_m) begin
            grant_if = last_dm_q;
            grant_dm = ~last_dm_q;
         end else begin
            grant_if = if_m;
            grant_dm = dm_m;
         end
      end
   end

   assign grant = grant_if | grant_dm;

   always_comb begin
      state_d = state_q;
      if (grant_if) begin
         state_d = ARB_IF;
      end else if (grant_dm) begin
         state_d = ARB_DM;
      end else if (done) begin
         state_d = ARB_IDLE;
      end
   end

   mem_lat_counter #(.W(CNT_W)) u_lat (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (grant),
      .load_val (LAT_LOAD),
      .en       (busy),
      .count    (lat_count),
      .done     (lat_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARB_IDLE;
         last_dm_q <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         dm_ack    <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         state_q <= state_d;
         mem_en  <= grant;
         if (grant) begin
            last_dm_q <= grant_dm;
         end
         if (grant_if) begin
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
         end else if (grant_dm) begin
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
         end
         if_ack <= done & (state_q == ARB_IF);
         dm_ack <= done & (state_q == ARB_DM);
         if (done && (state_q == ARB_IF)) begin
            if_rdata <= mem_rdata;
         end
         if (done && (state_q == ARB_DM)) begin
            dm_rdata <= mem_rdata;
         end
      end
   end

   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = dm_req & ~dm_ack;

   assign dbg.state     = state_q;
   assign dbg.last_dm   = last_dm_q;
   assign dbg.lat_count = lat_count;

`ifdef MEM_PORT_ARB_STATS_EN
   logic [15:0] conflict_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_q <= '0;
      end else if (if_req && dm_req && !if_ack && !dm_ack && (conflict_q != 16'hFFFF)) begin
         conflict_q <= conflict_q + 16'd1;
      end
   end

   assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// sequences for reset abort and (with MEM_PORT_ARB_STATS_EN) the conflict counter.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int AW      = 16;
   localparam int DW      = 16;
   localparam int MEM_LAT = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_ack;
   logic [DW-1:0] if_rdata;
   logic          dm_req = 1'b0;
   logic          dm_we = 1'b0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic          dm_ack;
   logic [DW-1:0] dm_rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = 16'hDEAD;
   logic          stall_if;
   logic          stall_mem;
   arb_dbg_t      dbg;
`ifdef MEM_PORT_ARB_STATS_EN
   logic [15:0]   conflict_cnt;
`endif

   mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_ack    (dm_ack),
      .dm_rdata  (dm_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall_if  (stall_if),
      .stall_mem (stall_mem),
      .dbg       (dbg)
`ifdef MEM_PORT_ARB_STATS_EN
      ,
      .conflict_cnt (conflict_cnt)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // Memory model: data is valid only in the cycle exactly MEM_LAT after mem_en.
   function automatic logic [15:0] mem_data(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hBBCD;
   endfunction

   int          age = 99;
   logic [15:0] lat_addr = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         age = 99;
      end else if (mem_en) begin
         age      = 0;
         lat_addr = mem_addr;
      end else if (age < 99) begin
         age++;
      end
      mem_rdata = (age == MEM_LAT) ? mem_data(lat_addr) : 16'hDEAD;
   end

   // ---------------- scoreboard ----------------
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      if_req   = 1'b0;
      if_addr  = '0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst mem_en",    32'(mem_en), 0);
      chk("rst mem_we",    32'(mem_we), 0);
      chk("rst mem_addr",  32'(mem_addr), 0);
      chk("rst mem_wdata", 32'(mem_wdata), 0);
      chk("rst acks",      32'({if_ack, dm_ack}), 0);
      chk("rst rdata",     32'({if_rdata, dm_rdata}), 0);
      chk("rst state",     32'(dbg.state), 32'(ARB_IDLE));
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          rst;
      logic        ir;
      logic [15:0] ia;
      logic        dr;
      logic        dw;
      logic [15:0] da;
      logic [15:0] dd;
      logic        en;
      logic        we;
      logic [15:0] a;
      logic [15:0] wd;
      logic        ia_ck;
      logic        da_ck;
      logic        si;
      logic        sm;
      logic [15:0] rd;
   } vec_t;

   vec_t tbl[$];
   vec_t t;

   task automatic add(input bit rst, input logic ir, input logic [15:0] ia, input logic dr,
                      input logic dw, input logic [15:0] da, input logic [15:0] dd,
                      input logic en, input logic we, input logic [15:0] a, input logic [15:0] wd,
                      input logic ia_ck, input logic da_ck, input logic si, input logic sm,
                      input logic [15:0] rd);
      vec_t v;
      v = '{rst, ir, ia, dr, dw, da, dd, en, we, a, wd, ia_ck, da_ck, si, sm, rd};
      tbl.push_back(v);
   endtask

   int          en_cyc, ack_cyc;
   logic [15:0] got_rd;
   bit          stray_ack;

   initial begin
      // Fetch alone, req held through the ack for a second fetch (ack-cycle mask).
      //  rst ir ia         dr dw da         dd          en we a          wd         ia da si sm rd
      add(1, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000);
      add(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000,  1, 0, 16'h0010, 16'h0000, 0, 0, 1, 0, 16'h0000);
      add(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000);
      add(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000);
      add(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'hABCD);
      add(0, 1, 16'h0012, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000);
      add(0, 1, 16'h0012, 0, 0, 16'h0000, 16'h0000,  1, 0, 16'h0012, 16'h0000, 0, 0, 1, 0, 16'h0000);
      add(0, 1, 16'h0012, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000);
      add(0, 1, 16'h0012, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000);
      add(0, 1, 16'h0012, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'hA9CD);
      add(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000);
      // First conflict after reset goes to DM, then sustained conflict DM, IF, DM, IF.
      add(1, 1, 16'h0010, 1, 1, 16'h0200, 16'h1234,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0000);
      add(0, 1, 16'h0010, 1, 1, 16'h0200, 16'h1234,  1, 1, 16'h0200, 16'h1234, 0, 0, 1, 1, 16'h0000);
      add(0, 1, 16'h0010, 1, 1, 16'h0200, 16'h1234,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0000);
      add(0, 1, 16'h0010, 1, 1, 16'h0200, 16'h1234,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0000);
      add(0, 1, 16'h0010, 1, 1, 16'h0200, 16'h1234,  1, 0, 16'h0010, 16'h0000, 0, 1, 1, 0, 16'hBBCF);
      add(0, 1, 16'h0010, 1, 0, 16'h0202, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0000);
      add(0, 1, 16'h0010, 1, 0, 16'h0202, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0000);
      add(0, 1, 16'h0010, 1, 0, 16'h0202, 16'h0000,  1, 0, 16'h0202, 16'h0000, 1, 0, 0, 1, 16'hABCD);
      add(0, 1, 16'h0014, 1, 0, 16'h0202, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0000);
      add(0, 1, 16'h0014, 1, 0, 16'h0202, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0000);
      add(0, 1, 16'h0014, 1, 0, 16'h0202, 16'h0000,  1, 0, 16'h0014, 16'h0000, 0, 1, 1, 0, 16'hB9CF);
      add(0, 1, 16'h0014, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000);
      add(0, 1, 16'h0014, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000);
      add(0, 1, 16'h0014, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'hAFCD);
      add(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000);
      // DM alone, then an IDLE conflict with last grant DM: IF wins, DM follows.
      add(1, 0, 16'h0000, 1, 0, 16'h0300, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000);
      add(0, 0, 16'h0000, 1, 0, 16'h0300, 16'h0000,  1, 0, 16'h0300, 16'h0000, 0, 0, 0, 1, 16'h0000);
      add(0, 0, 16'h0000, 1, 0, 16'h0300, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000);
      add(0, 0, 16'h0000, 1, 0, 16'h0300, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000);
      add(0, 0, 16'h0000, 1, 0, 16'h0300, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'hBBCE);
      add(0, 1, 16'h0010, 1, 1, 16'h0302, 16'h5555,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0000);
      add(0, 1, 16'h0010, 1, 1, 16'h0302, 16'h5555,  1, 0, 16'h0010, 16'h0000, 0, 0, 1, 1, 16'h0000);
      add(0, 1, 16'h0010, 1, 1, 16'h0302, 16'h5555,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0000);
      add(0, 1, 16'h0010, 1, 1, 16'h0302, 16'h5555,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0000);
      add(0, 1, 16'h0010, 1, 1, 16'h0302, 16'h5555,  1, 1, 16'h0302, 16'h5555, 1, 0, 0, 1, 16'hABCD);
      add(0, 0, 16'h0000, 1, 1, 16'h0302, 16'h5555,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000);
      add(0, 0, 16'h0000, 1, 1, 16'h0302, 16'h5555,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000);
      add(0, 0, 16'h0000, 1, 1, 16'h0302, 16'h5555,  0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'hB9CE);
      add(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000);

      for (int i = 0; i < tbl.size(); i++) begin
         t = tbl[i];
         if (t.rst) do_reset();
         if_req   = t.ir;
         if_addr  = t.ia;
         dm_req   = t.dr;
         dm_we    = t.dw;
         dm_addr  = t.da;
         dm_wdata = t.dd;
         @(negedge clk);
         chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(t.en));
         if (t.en) begin
            chk($sformatf("v%0d mem_we", i),    32'(mem_we), 32'(t.we));
            chk($sformatf("v%0d mem_addr", i),  32'(mem_addr), 32'(t.a));
            chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(t.wd));
         end
         chk($sformatf("v%0d if_ack", i),    32'(if_ack), 32'(t.ia_ck));
         chk($sformatf("v%0d dm_ack", i),    32'(dm_ack), 32'(t.da_ck));
         chk($sformatf("v%0d stall_if", i),  32'(stall_if), 32'(t.si));
         chk($sformatf("v%0d stall_mem", i), 32'(stall_mem), 32'(t.sm));
         if (t.ia_ck) chk($sformatf("v%0d if_rdata", i), 32'(if_rdata), 32'(t.rd));
         if (t.da_ck) chk($sformatf("v%0d dm_rdata", i), 32'(dm_rdata), 32'(t.rd));
         @(posedge clk); #1;
      end

      // Reset asserted in the third cycle of a DM load aborts it.
      do_reset();
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 16'h0400;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("abort pre addr", 32'(mem_addr), 32'h0400);
      rst_n  = 1'b0;
      dm_req = 1'b0;
      #1;
      chk("abort mem_en",   32'(mem_en), 0);
      chk("abort mem_addr", 32'(mem_addr), 0);
      chk("abort state",    32'(dbg.state), 32'(ARB_IDLE));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stray_ack = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (dm_ack || mem_en) stray_ack = 1'b1;
      end
      chk("abort no dm_ack", 32'(stray_ack), 0);
      @(posedge clk); #1;
      if_req  = 1'b1;
      if_addr = 16'h0010;
      en_cyc  = -1;
      ack_cyc = -1;
      got_rd  = '0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (mem_en && en_cyc < 0) en_cyc = k;
         if (if_ack && ack_cyc < 0) begin
            ack_cyc = k;
            got_rd  = if_rdata;
         end
         @(posedge clk); #1;
         if (ack_cyc >= 0) if_req = 1'b0;
      end
      chk("post-abort mem_en cycle", 32'(en_cyc), 1);
      chk("post-abort if_ack cycle", 32'(ack_cyc), 4);
      chk("post-abort if_rdata",     32'(got_rd), 32'hABCD);

`ifdef MEM_PORT_ARB_STATS_EN
      // Ten conflict cycles containing the dm_ack (cycle 4) and if_ack (cycle 7).
      do_reset();
      chk("cnt reset", 32'(conflict_cnt), 0);
      if_req  = 1'b1;
      if_addr = 16'h0010;
      dm_req  = 1'b1;
      dm_addr = 16'h0500;
      repeat (10) begin
         @(posedge clk); #1;
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      @(negedge clk);
      chk("cnt after 10", 32'(conflict_cnt), 8);
      do_reset();
      force dut.conflict_q = 16'hFFFD;
      #1;
      release dut.conflict_q;
      if_req = 1'b1;
      dm_req = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      @(negedge clk);
      chk("cnt saturate", 32'(conflict_cnt), 32'hFFFF);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1);
   end

endmodule
